// File: rtl/lsq_unit_pkg.sv
// lsq_unit_pkg: shared defaults, LS_TYPE field layout and address helper for the load/store queue.
package lsq_unit_pkg;
  localparam int LSQ_SIZE_BIT_DEF = 3;
  localparam int ROB_WIDTH_BIT_DEF = 4;
  localparam int NUM_WB_DEF = 2;
  localparam logic [1:0] IO_BASE_HI_DEF = 2'b11;
  localparam int TYPE_STORE = 3;
  typedef enum logic [1:0] {SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2} ls_size_e;
  function automatic logic [31:0] calc_ea(input logic [31:0] base, input logic [11:0] off);
    return base + {{20{off[11]}}, off};
  endfunction
endpackage

// File: rtl/lsq_wakeup_match.sv
// lsq_wakeup_match: priority compare of one tag against all result buses, lowest bus index wins.
module lsq_wakeup_match #(
  parameter int NUM_WB = 2,
  parameter int W = 4
) (
  input  logic [W-1:0]        tag_i,
  input  logic [NUM_WB-1:0]   wb_valid_i,
  input  logic [NUM_WB*W-1:0] wb_rob_id_i,
  input  logic [NUM_WB*32-1:0] wb_value_i,
  output logic                hit_o,
  output logic [31:0]         value_o
);
  always_comb begin
    hit_o = 1'b0;
    value_o = '0;
    for (int i = NUM_WB - 1; i >= 0; i--) begin
      if (wb_valid_i[i] && wb_rob_id_i[i*W +: W] == tag_i) begin
        hit_o = 1'b1;
        value_o = wb_value_i[i*32 +: 32];
      end
    end
  end
endmodule

// File: rtl/lsq_unit.sv
// lsq_unit: in-order load/store queue with operand wakeup, IO-ordered loads, held cache requests and flush.
module lsq_unit
  import lsq_unit_pkg::*;
#(
  parameter int LSQ_SIZE_BIT = LSQ_SIZE_BIT_DEF,
  parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF,
  parameter int NUM_WB = NUM_WB_DEF,
  parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          inst_valid,
  input  logic [3:0]                    inst_type,
  input  logic [31:0]                   inst_r1,
  input  logic [31:0]                   inst_r2,
  input  logic [ROB_WIDTH_BIT-1:0]      inst_dep1,
  input  logic [ROB_WIDTH_BIT-1:0]      inst_dep2,
  input  logic                          inst_has_dep1,
  input  logic                          inst_has_dep2,
  input  logic [11:0]                   inst_offset,
  input  logic [ROB_WIDTH_BIT-1:0]      inst_rob_id,
  output logic                          full,
  input  logic                          rob_head_valid,
  input  logic [ROB_WIDTH_BIT-1:0]      rob_head_id,
  input  logic                          flush_in,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB*ROB_WIDTH_BIT-1:0] wb_rob_id,
  input  logic [NUM_WB*32-1:0]          wb_value,
  output logic                          cache_valid,
  output logic                          cache_wr,
  output logic [2:0]                    cache_size,
  output logic [31:0]                   cache_addr,
  output logic [31:0]                   cache_value,
  input  logic                          cache_ready,
  input  logic [31:0]                   cache_res,
  output logic                          out_valid,
  output logic [ROB_WIDTH_BIT-1:0]      out_rob_id,
  output logic [31:0]                   out_value
);
  localparam int DEPTH = 1 << LSQ_SIZE_BIT;
  localparam int PW = LSQ_SIZE_BIT;
  localparam int CW = LSQ_SIZE_BIT + 1;
  localparam int RW = ROB_WIDTH_BIT;
  localparam logic [CW-1:0] FULL_CNT = {1'b1, {PW{1'b0}}};
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_nx, cand;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d, hd1_q, hd1_d, hd2_q, hd2_d, hit1, hit2, elig;
  logic [3:0] typ_q [DEPTH], typ_d [DEPTH];
  logic [31:0] r1_q [DEPTH], r1_d [DEPTH], r2_q [DEPTH], r2_d [DEPTH];
  logic [31:0] val1 [DEPTH], val2 [DEPTH], ea [DEPTH];
  logic [11:0] off_q [DEPTH], off_d [DEPTH];
  logic [RW-1:0] dep1_q [DEPTH], dep1_d [DEPTH], dep2_q [DEPTH], dep2_d [DEPTH];
  logic [RW-1:0] rob_q [DEPTH], rob_d [DEPTH];
  logic inflight_q, inflight_d, killed_q, killed_d;
  logic cache_valid_q, cache_valid_d, cache_wr_q, cache_wr_d;
  logic [2:0] cache_size_q, cache_size_d;
  logic [31:0] cache_addr_q, cache_addr_d, cache_value_q, cache_value_d;
  logic p_hit1, p_hit2, complete, push, can_issue;
  logic [31:0] p_val1, p_val2;
  genvar e;
  generate
    for (e = 0; e < DEPTH; e++) begin : g_ent
      lsq_wakeup_match #(.NUM_WB(NUM_WB), .W(RW)) u_m1 (
        .tag_i(dep1_q[e]), .wb_valid_i(wb_valid), .wb_rob_id_i(wb_rob_id),
        .wb_value_i(wb_value), .hit_o(hit1[e]), .value_o(val1[e]));
      lsq_wakeup_match #(.NUM_WB(NUM_WB), .W(RW)) u_m2 (
        .tag_i(dep2_q[e]), .wb_valid_i(wb_valid), .wb_rob_id_i(wb_rob_id),
        .wb_value_i(wb_value), .hit_o(hit2[e]), .value_o(val2[e]));
      assign ea[e] = calc_ea(r1_q[e], off_q[e]);
      // stores and IO-space loads may only go once they are the oldest ROB entry
      assign elig[e] = busy_q[e] && !hd1_q[e] && !hd2_q[e] &&
                       (!(typ_q[e][TYPE_STORE] || ea[e][17:16] == IO_BASE_HI) ||
                        (rob_head_valid && rob_q[e] == rob_head_id));
    end
  endgenerate
  lsq_wakeup_match #(.NUM_WB(NUM_WB), .W(RW)) u_p1 (
    .tag_i(inst_dep1), .wb_valid_i(wb_valid), .wb_rob_id_i(wb_rob_id),
    .wb_value_i(wb_value), .hit_o(p_hit1), .value_o(p_val1));
  lsq_wakeup_match #(.NUM_WB(NUM_WB), .W(RW)) u_p2 (
    .tag_i(inst_dep2), .wb_valid_i(wb_valid), .wb_rob_id_i(wb_rob_id),
    .wb_value_i(wb_value), .hit_o(p_hit2), .value_o(p_val2));
  assign full = count_q == FULL_CNT;
  assign head_nx = head_q + PW'(1);
  assign complete = rdy_in && cache_ready && inflight_q;
  assign cand = complete ? head_nx : head_q;
  assign push = inst_valid && !flush_in && !full;
  assign can_issue = !flush_in && (!inflight_q || complete) && elig[cand];
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    busy_d = busy_q;
    hd1_d = hd1_q;
    hd2_d = hd2_q;
    typ_d = typ_q;
    r1_d = r1_q;
    r2_d = r2_q;
    off_d = off_q;
    dep1_d = dep1_q;
    dep2_d = dep2_q;
    rob_d = rob_q;
    inflight_d = inflight_q;
    killed_d = killed_q;
    cache_valid_d = cache_valid_q;
    cache_wr_d = cache_wr_q;
    cache_size_d = cache_size_q;
    cache_addr_d = cache_addr_q;
    cache_value_d = cache_value_q;
    if (flush_in) begin
      busy_d = '0;
      hd1_d = '0;
      hd2_d = '0;
      if (inflight_q && !complete) busy_d[head_q] = 1'b1;
      head_d = complete ? head_nx : head_q;
      tail_d = inflight_q ? head_nx : head_q;
      count_d = (inflight_q && !complete) ? CW'(1) : '0;
      inflight_d = inflight_q && !complete;
      killed_d = inflight_q && !complete;
      cache_valid_d = inflight_q && !complete;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && hd1_q[i] && hit1[i]) begin
          r1_d[i] = val1[i];
          hd1_d[i] = 1'b0;
        end
        if (busy_q[i] && hd2_q[i] && hit2[i]) begin
          r2_d[i] = val2[i];
          hd2_d[i] = 1'b0;
        end
      end
      if (complete) begin
        busy_d[head_q] = 1'b0;
        head_d = head_nx;
        inflight_d = 1'b0;
        killed_d = 1'b0;
        cache_valid_d = 1'b0;
      end
      if (push) begin
        busy_d[tail_q] = 1'b1;
        typ_d[tail_q] = inst_type;
        off_d[tail_q] = inst_offset;
        rob_d[tail_q] = inst_rob_id;
        dep1_d[tail_q] = inst_dep1;
        dep2_d[tail_q] = inst_dep2;
        r1_d[tail_q] = (inst_has_dep1 && p_hit1) ? p_val1 : inst_r1;
        r2_d[tail_q] = (inst_has_dep2 && p_hit2) ? p_val2 : inst_r2;
        hd1_d[tail_q] = inst_has_dep1 && !p_hit1;
        hd2_d[tail_q] = inst_has_dep2 && !p_hit2;
        tail_d = tail_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(complete);
      if (can_issue) begin
        inflight_d = 1'b1;
        cache_valid_d = 1'b1;
        cache_wr_d = typ_q[cand][TYPE_STORE];
        cache_size_d = typ_q[cand][2:0];
        cache_addr_d = ea[cand];
        cache_value_d = r2_q[cand];
      end
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      busy_q <= '0;
      hd1_q <= '0;
      hd2_q <= '0;
      typ_q <= '{default: '0};
      r1_q <= '{default: '0};
      r2_q <= '{default: '0};
      off_q <= '{default: '0};
      dep1_q <= '{default: '0};
      dep2_q <= '{default: '0};
      rob_q <= '{default: '0};
      inflight_q <= 1'b0;
      killed_q <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_wr_q <= 1'b0;
      cache_size_q <= '0;
      cache_addr_q <= '0;
      cache_value_q <= '0;
    end else if (rdy_in) begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      busy_q <= busy_d;
      hd1_q <= hd1_d;
      hd2_q <= hd2_d;
      typ_q <= typ_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      off_q <= off_d;
      dep1_q <= dep1_d;
      dep2_q <= dep2_d;
      rob_q <= rob_d;
      inflight_q <= inflight_d;
      killed_q <= killed_d;
      cache_valid_q <= cache_valid_d;
      cache_wr_q <= cache_wr_d;
      cache_size_q <= cache_size_d;
      cache_addr_q <= cache_addr_d;
      cache_value_q <= cache_value_d;
    end
  end
  assign cache_valid = cache_valid_q;
  assign cache_wr = cache_wr_q;
  assign cache_size = cache_size_q;
  assign cache_addr = cache_addr_q;
  assign cache_value = cache_value_q;
  assign out_valid = complete && !killed_q && !flush_in;
  assign out_rob_id = out_valid ? rob_q[head_q] : '0;
  assign out_value = (out_valid && !typ_q[head_q][TYPE_STORE]) ? cache_res : '0;
  push_while_full: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(rdy_in && inst_valid && !flush_in && full));
endmodule

// File: tb/tb_lsq_unit.sv
// tb_lsq_unit: directed scenario tests for lsq_unit with hand-computed expectations.
module tb_lsq_unit;
  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
  logic inst_valid = 1'b0, inst_has_dep1 = 1'b0, inst_has_dep2 = 1'b0;
  logic [3:0] inst_type = '0, inst_dep1 = '0, inst_dep2 = '0, inst_rob_id = '0;
  logic [31:0] inst_r1 = '0, inst_r2 = '0;
  logic [11:0] inst_offset = '0;
  logic full, rob_head_valid = 1'b0, flush_in = 1'b0;
  logic [3:0] rob_head_id = '0;
  logic [1:0] wb_valid = '0;
  logic [7:0] wb_rob_id = '0;
  logic [63:0] wb_value = '0;
  logic cache_valid, cache_wr, cache_ready = 1'b0, out_valid;
  logic [2:0] cache_size;
  logic [31:0] cache_addr, cache_value, cache_res = '0, out_value;
  logic [3:0] out_rob_id;
  int checks = 0, errors = 0;

  lsq_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .inst_valid(inst_valid),
    .inst_type(inst_type), .inst_r1(inst_r1), .inst_r2(inst_r2),
    .inst_dep1(inst_dep1), .inst_dep2(inst_dep2), .inst_has_dep1(inst_has_dep1),
    .inst_has_dep2(inst_has_dep2), .inst_offset(inst_offset), .inst_rob_id(inst_rob_id),
    .full(full), .rob_head_valid(rob_head_valid), .rob_head_id(rob_head_id),
    .flush_in(flush_in), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .cache_valid(cache_valid), .cache_wr(cache_wr), .cache_size(cache_size),
    .cache_addr(cache_addr), .cache_value(cache_value), .cache_ready(cache_ready),
    .cache_res(cache_res), .out_valid(out_valid), .out_rob_id(out_rob_id), .out_value(out_value)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [3:0] t, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [11:0] off, input logic [3:0] rob,
                      input logic [3:0] d2, input logic h2);
    inst_valid = 1'b1;
    inst_type = t;
    inst_r1 = r1;
    inst_r2 = r2;
    inst_offset = off;
    inst_rob_id = rob;
    inst_dep2 = d2;
    inst_has_dep2 = h2;
    tick();
    inst_valid = 1'b0;
    inst_has_dep2 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL reset_cv got %b exp 0", cache_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov got %b exp 0", out_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", cache_addr); end
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_load();
    push(4'b0010, 32'h1000, 32'h0, 12'hFFC, 4'd3, 4'd0, 1'b0);
    checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL load_early got %b exp 0", cache_valid); end
    tick();
    checks++; if (cache_valid !== 1'b1) begin errors++; $display("FAIL load_cv got %b exp 1", cache_valid); end
    checks++; if (cache_addr !== 32'hFFC) begin errors++; $display("FAIL load_addr got %h exp ffc", cache_addr); end
    checks++; if (cache_size !== 3'd2 || cache_wr !== 1'b0) begin errors++; $display("FAIL load_sizewr got %0d/%b exp 2/0", cache_size, cache_wr); end
    cache_ready = 1'b1;
    cache_res = 32'hDEADBEEF;
    #1;
    checks++; if (out_valid !== 1'b1 || out_rob_id !== 4'd3) begin errors++; $display("FAIL load_out got %b/%0d exp 1/3", out_valid, out_rob_id); end
    checks++; if (out_value !== 32'hDEADBEEF) begin errors++; $display("FAIL load_val got %h exp deadbeef", out_value); end
    tick();
    cache_ready = 1'b0;
    #1;
    checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL load_drop got %b exp 0", cache_valid); end
  endtask

  task automatic test_store_bypass();
    rob_head_valid = 1'b1;
    rob_head_id = 4'd7;
    wb_valid = 2'b10;
    wb_rob_id = {4'd5, 4'd0};
    wb_value = {32'h55, 32'h0};
    push(4'b1010, 32'h2000, 32'h0, 12'h008, 4'd7, 4'd5, 1'b1);
    wb_valid = 2'b00;
    tick();
    checks++; if (cache_valid !== 1'b1 || cache_wr !== 1'b1) begin errors++; $display("FAIL st_cvwr got %b/%b exp 1/1", cache_valid, cache_wr); end
    checks++; if (cache_value !== 32'h55) begin errors++; $display("FAIL st_value got %h exp 55", cache_value); end
    checks++; if (cache_addr !== 32'h2008) begin errors++; $display("FAIL st_addr got %h exp 2008", cache_addr); end
    cache_ready = 1'b1;
    cache_res = 32'h9999;
    #1;
    checks++; if (out_valid !== 1'b1 || out_rob_id !== 4'd7 || out_value !== 32'h0) begin errors++; $display("FAIL st_out got %b/%0d/%h exp 1/7/0", out_valid, out_rob_id, out_value); end
    tick();
    cache_ready = 1'b0;
  endtask

  task automatic test_wakeup();
    rob_head_id = 4'd8;
    push(4'b1010, 32'h3000, 32'h0, 12'h000, 4'd8, 4'd6, 1'b1);
    tick();
    checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL wk_wait got %b exp 0", cache_valid); end
    wb_valid = 2'b11;
    wb_rob_id = {4'd6, 4'd6};
    wb_value = {32'hBB, 32'hAA};
    tick();
    wb_valid = 2'b00;
    tick();
    checks++; if (cache_valid !== 1'b1 || cache_value !== 32'hAA) begin errors++; $display("FAIL wk_prio got %b/%h exp 1/aa", cache_valid, cache_value); end
    cache_ready = 1'b1;
    tick();
    cache_ready = 1'b0;
  endtask

  task automatic test_io_pause();
    rob_head_id = 4'd9;
    push(4'b0010, 32'h30000, 32'h0, 12'h004, 4'd2, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL io_hold%0d got %b exp 0", i, cache_valid); end
    end
    rob_head_id = 4'd2;
    tick();
    checks++; if (cache_valid !== 1'b1 || cache_addr !== 32'h30004) begin errors++; $display("FAIL io_issue got %b/%h exp 1/30004", cache_valid, cache_addr); end
    rdy_in = 1'b0;
    cache_ready = 1'b1;
    cache_res = 32'h1234;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pause_ov got %b exp 0", out_valid); end
    tick();
    checks++; if (cache_valid !== 1'b1 || cache_addr !== 32'h30004) begin errors++; $display("FAIL pause_hold got %b/%h exp 1/30004", cache_valid, cache_addr); end
    rdy_in = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_rob_id !== 4'd2 || out_value !== 32'h1234) begin errors++; $display("FAIL io_out got %b/%0d/%h exp 1/2/1234", out_valid, out_rob_id, out_value); end
    tick();
    cache_ready = 1'b0;
    #1;
    checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL io_drop got %b exp 0", cache_valid); end
  endtask

  task automatic test_full_wrap();
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 8; i++)
        push(4'b0010, 32'h100 * (i + 1) + lap * 4, 32'h0, 12'h000, 4'(i + lap * 5), 4'd0, 1'b0);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set lap%0d got %b exp 1", lap, full); end
      cache_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b1 || out_rob_id !== 4'(lap * 5)) begin errors++; $display("FAIL full_out0 lap%0d got %b/%0d exp 1/%0d", lap, out_valid, out_rob_id, 4'(lap * 5)); end
      tick();
      cache_ready = 1'b0;
      #1;
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_clr lap%0d got %b exp 0", lap, full); end
      checks++; if (cache_valid !== 1'b1 || cache_addr !== 32'h200 + lap * 4) begin errors++; $display("FAIL full_next lap%0d got %b/%h exp 1/%h", lap, cache_valid, cache_addr, 32'h200 + lap * 4); end
      cache_ready = 1'b1;
      for (int k = 1; k < 8; k++) begin
        #1;
        checks++; if (out_valid !== 1'b1 || out_rob_id !== 4'(k + lap * 5)) begin errors++; $display("FAIL drain lap%0d k%0d got %b/%0d exp 1/%0d", lap, k, out_valid, out_rob_id, 4'(k + lap * 5)); end
        tick();
      end
      cache_ready = 1'b0;
      #1;
      checks++; if (cache_valid !== 1'b0 || dut.count_q !== 4'd0) begin errors++; $display("FAIL drained lap%0d got %b/%0d exp 0/0", lap, cache_valid, dut.count_q); end
    end
  endtask

  task automatic test_back_to_back();
    push(4'b0010, 32'h40, 32'h0, 12'h000, 4'd10, 4'd0, 1'b0);
    push(4'b0010, 32'h80, 32'h0, 12'h000, 4'd11, 4'd0, 1'b0);
    checks++; if (cache_valid !== 1'b1 || cache_addr !== 32'h40) begin errors++; $display("FAIL b2b_first got %b/%h exp 1/40", cache_valid, cache_addr); end
    cache_ready = 1'b1;
    cache_res = 32'h11;
    #1;
    checks++; if (out_valid !== 1'b1 || out_rob_id !== 4'd10 || out_value !== 32'h11) begin errors++; $display("FAIL b2b_out1 got %b/%0d/%h exp 1/10/11", out_valid, out_rob_id, out_value); end
    tick();
    cache_res = 32'h22;
    #1;
    checks++; if (cache_valid !== 1'b1 || cache_addr !== 32'h80) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/80", cache_valid, cache_addr); end
    checks++; if (out_valid !== 1'b1 || out_rob_id !== 4'd11 || out_value !== 32'h22) begin errors++; $display("FAIL b2b_out2 got %b/%0d/%h exp 1/11/22", out_valid, out_rob_id, out_value); end
    tick();
    cache_ready = 1'b0;
    #1;
    checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b exp 0", cache_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++)
      push(4'b0010, 32'h500 + i * 16, 32'h0, 12'h000, 4'(i), 4'd0, 1'b0);
    checks++; if (dut.count_q !== 4'd4 || cache_addr !== 32'h500) begin errors++; $display("FAIL fl_pre got %0d/%h exp 4/500", dut.count_q, cache_addr); end
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    checks++; if (dut.count_q !== 4'd1 || cache_valid !== 1'b1 || cache_addr !== 32'h500) begin errors++; $display("FAIL fl_keep got %0d/%b/%h exp 1/1/500", dut.count_q, cache_valid, cache_addr); end
    cache_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_kill got %b exp 0", out_valid); end
    tick();
    cache_ready = 1'b0;
    #1;
    checks++; if (dut.count_q !== 4'd0 || cache_valid !== 1'b0) begin errors++; $display("FAIL fl_empty got %0d/%b exp 0/0", dut.count_q, cache_valid); end
    tick();
    tick();
    checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL fl_stale got %b exp 0", cache_valid); end
    push(4'b0010, 32'h600, 32'h0, 12'h000, 4'd4, 4'd0, 1'b0);
    push(4'b0010, 32'h610, 32'h0, 12'h000, 4'd5, 4'd0, 1'b0);
    flush_in = 1'b1;
    cache_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flc_ov got %b exp 0", out_valid); end
    tick();
    flush_in = 1'b0;
    cache_ready = 1'b0;
    #1;
    checks++; if (dut.count_q !== 4'd0 || cache_valid !== 1'b0) begin errors++; $display("FAIL flc_empty got %0d/%b exp 0/0", dut.count_q, cache_valid); end
    push(4'b0010, 32'h700, 32'h0, 12'h000, 4'd6, 4'd0, 1'b0);
    tick();
    cache_ready = 1'b1;
    cache_res = 32'h77;
    #1;
    checks++; if (out_valid !== 1'b1 || out_rob_id !== 4'd6 || out_value !== 32'h77) begin errors++; $display("FAIL fl_resume got %b/%0d/%h exp 1/6/77", out_valid, out_rob_id, out_value); end
    tick();
    cache_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_bypass();
    test_wakeup();
    test_io_pause();
    rob_head_valid = 1'b0;
    test_full_wrap();
    test_back_to_back();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
